// File: rtl/gfx_pkg.sv
// Shared graphics types for the projection -> raster -> framebuffer path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gfx_pkg;

    localparam int COORD_W = 9;
    localparam logic [COORD_W-1:0] SCREEN_W_MAX = 9'd511;
    localparam logic [11:0] COLOR = 12'hFFF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef enum logic [1:0] {
        COLLECT,
        SETUP,
        DRAW,
        DONE
    } raster_state_t;

endpackage

// File: rtl/line_stepper.sv
// Integer Bresenham stepper for one edge; load captures endpoints, advance steps one pixel.
// Latency: position valid the cycle after load; one step per advance.
// Backpressure: holds position whenever advance is low.
module line_stepper
    import gfx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W-1:0] x_end, y_end;
    logic signed [10:0] dx, dy, err;
    logic               sx_neg, sy_neg;

    logic signed [10:0] dx_raw, dy_raw, dx_abs, dy_abs;
    logic signed [11:0] e2, dx_w, dy_w;
    logic signed [10:0] err_next;
    logic               step_x, step_y;

    always_comb begin
        dx_raw   = $signed({2'b00, x1}) - $signed({2'b00, x0});
        dy_raw   = $signed({2'b00, y1}) - $signed({2'b00, y0});
        dx_abs   = dx_raw[10] ? -dx_raw : dx_raw;
        dy_abs   = dy_raw[10] ? -dy_raw : dy_raw;
        dx_w     = dx;
        dy_w     = dy;
        e2       = {err, 1'b0};
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        // Both corrections are taken from the pre-step error term.
        err_next = err + (step_x ? dy : 11'sd0) + (step_y ? dx : 11'sd0);
        last     = (x == x_end) && (y == y_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            x_end  <= '0;
            y_end  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            x      <= x0;
            y      <= y0;
            x_end  <= x1;
            y_end  <= y1;
            dx     <= dx_abs;
            dy     <= -dy_abs;
            err    <= dx_abs - dy_abs;
            sx_neg <= !(x0 < x1);
            sy_neg <= !(y0 < y1);
        end else if (advance) begin
            err <= err_next;
            if (step_x) x <= sx_neg ? x - 9'd1 : x + 9'd1;
            if (step_y) y <= sy_neg ? y - 9'd1 : y + 9'd1;
        end
    end

endmodule

// File: rtl/tri_wire_raster.sv
// Wireframe rasterizer: collects three vertices, walks v0->v1->v2->v0, one pixel per cycle.
// Latency: first pixel valid two cycles after the third vertex is accepted; one SETUP bubble per edge.
// Backpressure: pixel held stable until pix_ready_in; vertices refused (ready_out=0) while drawing.
module tri_wire_raster
    import gfx_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [2:0][COORD_W-1:0] coor_in,
    input  logic                   valid_in,
    input  logic                   obj_done_in,
    output logic                   ready_out,
    output logic [COORD_W-1:0]     pix_x_out,
    output logic [COORD_W-1:0]     pix_y_out,
    output logic [11:0]            pix_color_out,
    output logic                   pix_valid_out,
    input  logic                   pix_ready_in,
    output logic                   obj_done_out
);

    raster_state_t      state;
    logic [1:0]         vcnt, edge_idx;
    logic               done_acc;
    logic [COORD_W-1:0] vx [3];
    logic [COORD_W-1:0] vy [3];

    vertex_t            vin;
    logic               unused_z;
    logic               accept, load, advance, last;
    logic [COORD_W-1:0] ex0, ey0, ex1, ey1;

    assign vin           = vertex_t'(coor_in);
    assign unused_z      = ^vin.z;
    assign accept        = (state == COLLECT) && valid_in && ready_out;
    assign load          = (state == SETUP);
    assign advance       = (state == DRAW) && pix_ready_in && !last;
    assign pix_color_out = COLOR;

    always_comb begin
        ex0 = vx[2];
        ey0 = vy[2];
        ex1 = vx[0];
        ey1 = vy[0];
        case (edge_idx)
            2'd0: begin ex0 = vx[0]; ey0 = vy[0]; ex1 = vx[1]; ey1 = vy[1]; end
            2'd1: begin ex0 = vx[1]; ey0 = vy[1]; ex1 = vx[2]; ey1 = vy[2]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            vx[vcnt] <= vin.x;
            vy[vcnt] <= vin.y;
        end
    end

    line_stepper u_stepper (
        .clk     (clk_in),
        .rst     (rst_in),
        .load    (load),
        .x0      (ex0),
        .y0      (ey0),
        .x1      (ex1),
        .y1      (ey1),
        .advance (advance),
        .x       (pix_x_out),
        .y       (pix_y_out),
        .last    (last)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= COLLECT;
            vcnt          <= '0;
            edge_idx      <= '0;
            done_acc      <= 1'b0;
            ready_out     <= 1'b0;
            pix_valid_out <= 1'b0;
            obj_done_out  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    obj_done_out <= 1'b0;
                    ready_out    <= 1'b1;
                    if (accept) begin
                        done_acc <= done_acc | obj_done_in;
                        if (vcnt == 2'd2) begin
                            state     <= SETUP;
                            edge_idx  <= '0;
                            ready_out <= 1'b0;
                        end else begin
                            vcnt <= vcnt + 2'd1;
                        end
                    end
                end
                SETUP: begin
                    state         <= DRAW;
                    pix_valid_out <= 1'b1;
                end
                DRAW: begin
                    if (pix_ready_in && last) begin
                        pix_valid_out <= 1'b0;
                        if (edge_idx == 2'd2) begin
                            state        <= DONE;
                            obj_done_out <= done_acc;
                        end else begin
                            edge_idx <= edge_idx + 2'd1;
                            state    <= SETUP;
                        end
                    end
                end
                default: begin
                    obj_done_out <= 1'b0;
                    done_acc     <= 1'b0;
                    vcnt         <= '0;
                    ready_out    <= 1'b1;
                    state        <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/tri_wire_raster.md
# tri_wire_raster

Wireframe rasterizer directly downstream of the triangle projection stage. Collects three projected 9-bit screen vertices, then walks the three edges (v0→v1, v1→v2, v2→v0) with an integer Bresenham stepper. It emits one pixel coordinate per cycle to the framebuffer writer over a valid/ready handshake and forwards the object-done marker once the triangle is fully drawn.

## Interface
- COLOR, 12'hFFF, constant RGB444 value driven on `pix_color_out` for every pixel.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `coor_in` in [8:0] x3: projected vertex; [2]=x, [1]=y, [0]=z. z is ignored.
- `valid_in` in 1: vertex present; accepted when `valid_in && ready_out`.
- `obj_done_in` in 1: sideband qualified with `valid_in`.
- `ready_out` out 1: can accept a vertex.
- `pix_x_out` out 9: pixel x.
- `pix_y_out` out 9: pixel y.
- `pix_color_out` out 12: equals COLOR.
- `pix_valid_out` out 1: pixel present.
- `pix_ready_in` in 1: downstream accepts the pixel this cycle.
- `obj_done_out` out 1: one-cycle pulse after the last pixel of a triangle flagged done.

## Operation
- State machine: COLLECT → SETUP → DRAW → (SETUP | DONE) → COLLECT.
- COLLECT:
  - `ready_out`=1.
  - Each accepted vertex is stored at index `vcnt` (0..2).
  - `obj_done_in` values are OR-accumulated into `done_acc`.
  - Accepting the vertex at `vcnt`=2 moves to SETUP with edge=0. `ready_out` drops to 0 the following cycle.
- SETUP (1 cycle): edge e uses endpoints (v[e], v[(e+1)%3]) and loads:
  - `x`=x0, `y`=y0
  - `dx`=|x1−x0|, `dy`=−|y1−y0|
  - `sx`=+1 if x0<x1 else −1, `sy`=+1 if y0<y1 else −1
  - `err`=dx+dy
- DRAW: present (`x`,`y`). On a handshake:
  - If (`x`,`y`)==(x1,y1), the edge ends. With edge<2, increment edge and go to SETUP. With edge=2, go to DONE.
  - Otherwise, with e2=2·err: if e2≥dy then err+=dy and x+=sx. If e2≤dx then err+=dx and y+=sy. Both updates use the pre-update err.
- DONE (1 cycle): `obj_done_out`=`done_acc`. Then clear `done_acc` and `vcnt`, and go to COLLECT.
- Pixel count per edge is max(dx,−dy)+1.
- Shared vertices are emitted twice, once as the end of one edge and once as the start of the next. No deduplication.
- Arithmetic:
  - `dx`, `dy`, `err` are 11-bit signed. e2 is 12-bit signed.
  - Coordinates are unsigned 0..511. The stepper never leaves the endpoint bounding box, so no wrap handling is needed.
- Degenerate triangle (all vertices equal): exactly 3 pixels, all at that point.

## Timing
- Reset values:
  - `ready_out`=0, `pix_valid_out`=0, `pix_x_out`=0, `pix_y_out`=0, `obj_done_out`=0.
  - State=COLLECT, `vcnt`=0, `done_acc`=0.
  - `ready_out` rises the first cycle after `rst_in` deasserts.
- `rst_in` mid-triangle: drops all stored vertices and any pending pixel, returns to the reset values, and emits no `obj_done_out`.
- Outputs are registered.
  - `pix_valid_out` stays high and `pix_x_out`/`pix_y_out` stay stable until `pix_ready_in`.
  - `pix_valid_out` never drops without a handshake, except on reset.
- Latency: third vertex accepted at cycle T → SETUP at T+1 → first pixel valid at T+2.
- Throughput: 1 pixel/cycle while `pix_ready_in`=1.
  - One bubble cycle (SETUP) between edges.
  - One cycle (DONE) after the final pixel handshake, then `ready_out`=1 on the following cycle.
- Total cycles for a triangle with `pix_ready_in` tied high: N_pixels + 3 (SETUPs) + 1 (DONE).
- `valid_in` while `ready_out`=0 is ignored. Upstream holds its result until ready.
- Simultaneous `pix_ready_in` and end-of-edge: the handshake completes the edge. `pix_valid_out` is 0 in the SETUP cycle.

## Structure
- Shared package `gfx_pkg`:
  - `vertex_t` (x, y, z each 9 bits).
  - `raster_state_t` enum (COLLECT, SETUP, DRAW, DONE).
  - Screen width constant, 9 bits.
  - Default color constant.
- Sub-module `line_stepper`:
  - Inputs: load, endpoints, advance.
  - Outputs: x, y, last.
  - Holds dx/dy/sx/sy/err.
- The top level holds the vertex buffer, edge counter, FSM and output registers.

## Test plan
- Reset then vertices (10,10), (13,10), (10,12) back-to-back, `pix_ready_in`=1. Expected pixels:
  - (10,10) (11,10) (12,10) (13,10)
  - (13,10) (12,11) (11,11)? Bresenham from (13,10) to (10,12): (13,10) (12,11) (11,11) (10,12)
  - (10,12) (10,11) (10,10)
  - 11 pixels in total. First `pix_valid_out` at T+2.
- All three vertices (5,5): exactly 3 pixels at (5,5). `obj_done_out` pulses iff any vertex had `obj_done_in`=1.
- Edge (0,0)→(511,0): 512 pixels, x increments to 511 with no overflow. Reverse edge (511,511)→(0,0) steps with sx=sy=−1.
- `pix_ready_in` toggled randomly (50%): the pixel sequence is identical to the tied-high run, and each pixel is held stable while stalled.
- `valid_in` pulses while in DRAW: ignored, `ready_out`=0. The next triangle is accepted only after DONE.
- `rst_in` asserted mid-DRAW on the second edge: outputs return to their reset values next cycle, no `obj_done_out`, and a fresh triangle then draws correctly.
